// File: rtl/irq_controller.sv
// Eight-line interrupt front-end: synchronises and edge-detects irq_in, latches pending requests,
// masks them and hands the highest-priority vector to the core. Optional macro: IRQ_NESTING_EN.
module irq_controller #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned NUM_IRQ     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] irq_in,
  input  logic       mask_wr,
  input  logic [7:0] mask_data,
  input  logic       int_ack,
  input  logic       eoi,
  input  logic [7:0] pend_clr,
  output logic       int_request,
  output logic [2:0] int_vector,
  output logic [7:0] irq_masks,
  output logic [7:0] pending,
  output logic       in_service
);

  logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] sync_q;
  logic [NUM_IRQ-1:0] sync_out;
  logic [NUM_IRQ-1:0] sync_last_q;
  logic [NUM_IRQ-1:0] rise;

  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] masks_q;
  logic [NUM_IRQ-1:0] active;
  logic [NUM_IRQ-1:0] sel_onehot;
  logic [2:0]         sel;
  logic               any_active;
  logic [2:0]         vector_q;
  logic               ack_fire;
  logic               request;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign rise     = sync_out & ~sync_last_q;
  assign active   = pending_q & masks_q;
  assign any_active = |active;

  // Lowest set index wins: scan downwards so the last hit is the lowest.
  always_comb begin
    sel        = '0;
    sel_onehot = '0;
    for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
      if (active[i]) begin
        sel = 3'(i);
      end
    end
    sel_onehot[sel] = any_active;
  end

`ifdef IRQ_NESTING_EN
  logic [NUM_IRQ-1:0] isr_q, isr_d;
  logic [NUM_IRQ-1:0] isr_low_onehot;
  logic [2:0]         isr_low;
  logic               isr_any;

  assign isr_any = |isr_q;

  always_comb begin
    isr_low        = '0;
    isr_low_onehot = '0;
    for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
      if (isr_q[i]) begin
        isr_low = 3'(i);
      end
    end
    isr_low_onehot[isr_low] = isr_any;
  end

  // Only a strictly higher-priority line may preempt the one currently being serviced.
  assign request = any_active & (~isr_any | (sel < isr_low));

  always_comb begin
    isr_d = isr_q;
    if (eoi) begin
      isr_d = isr_d & ~isr_low_onehot;
    end
    if (ack_fire) begin
      isr_d = isr_d | sel_onehot;
    end
  end

  assign in_service = isr_any;
`else
  logic in_service_q, in_service_d;

  assign request = any_active & ~in_service_q;

  // Ack takes precedence over a coincident eoi.
  always_comb begin
    in_service_d = in_service_q;
    if (eoi) begin
      in_service_d = 1'b0;
    end
    if (ack_fire) begin
      in_service_d = 1'b1;
    end
  end

  assign in_service = in_service_q;
`endif

  assign ack_fire = int_ack & request;

  // A fresh edge beats both ack and pend_clr on the same bit.
  always_comb begin
    pending_d = pending_q & ~pend_clr;
    if (ack_fire) begin
      pending_d = pending_d & ~sel_onehot;
    end
    pending_d = pending_d | rise;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q       <= '0;
      sync_last_q  <= '0;
      pending_q    <= '0;
      masks_q      <= '0;
      vector_q     <= '0;
`ifdef IRQ_NESTING_EN
      isr_q        <= '0;
`else
      in_service_q <= 1'b0;
`endif
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], irq_in};
      sync_last_q <= sync_out;
      pending_q   <= pending_d;
      if (mask_wr) begin
        masks_q <= mask_data;
      end
      if (ack_fire) begin
        vector_q <= sel;
      end
`ifdef IRQ_NESTING_EN
      isr_q        <= isr_d;
`else
      in_service_q <= in_service_d;
`endif
    end
  end

  assign int_request = request;
  assign int_vector  = vector_q;
  assign irq_masks   = masks_q;
  assign pending     = pending_q;

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Interrupt front-end that sits directly upstream of the CPU core.
- Synchronises the eight external irq_in lines and latches rising edges as pending requests.
- Applies the interrupt mask register and drives int_request; the core gates int_request with its interrupt-enable status bit.
- On the core's acknowledge, supplies the highest-priority vector and tracks in-service state until end-of-interrupt.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops per irq line (min 2)
NUM_IRQ, 8, number of interrupt lines (fixed at 8; vector width 3)

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
irq_in  input  8  asynchronous external interrupt lines, rising-edge triggered
mask_wr  input  1  load irq_masks from mask_data this cycle
mask_data  input  8  new mask value, bit=1 enables line
int_ack  input  1  one-cycle acknowledge pulse from core microcode
eoi  input  1  one-cycle end-of-interrupt pulse
pend_clr  input  8  one-cycle bitmask, clears pending bits
int_request  output  1  unmasked request pending and not blocked by in-service
int_vector  output  3  vector latched at last accepted ack
irq_masks  output  8  current mask register
pending  output  8  pending latch contents
in_service  output  1  an acknowledged interrupt has not yet received eoi

Behaviour:
- Reset, sampled at posedge clk while rst_n=0:
  - sync chains, edge flops, pending, irq_masks, int_vector and in_service all go to 0.
  - int_request therefore reads 0.
  - Reset overrides every other input, including in mid-service.
- Synchronisation and edge detect:
  - irq_in[i] first sampled high at edge E.
  - The synchroniser output is high after edge E+SYNC_STAGES-1.
  - Rise = sync_out & ~sync_out_d.
  - pending[i] sets at edge E+SYNC_STAGES; with the default of 2, pending is visible 2 cycles after first sample.
  - A level held high produces exactly one pending set; it must go low and high again to re-trigger.
  - Pulses narrower than one clock are not guaranteed to be caught.
- Pending latches are set regardless of mask; masking only gates the request.
- Request:
  - int_request = |(pending & irq_masks) & ~in_service.
  - Combinational from registers only; no input-to-output path.
- Priority: bit 0 highest, bit 7 lowest; sel = lowest set index of (pending & irq_masks).
- Acknowledge, int_ack=1 while int_request=1, at the edge:
  - int_vector <= sel.
  - pending[sel] <= 0.
  - in_service <= 1.
- int_ack while int_request=0: ignored, no state change.
- EOI: in_service <= 0 at the edge. eoi while in_service=0 is ignored.
- Simultaneous events on the same bit in one cycle:
  - New edge with ack or pend_clr: set wins, so the bit stays pending.
  - ack together with eoi: ack wins, in_service stays 1.
- mask_wr:
  - irq_masks updates at the edge.
  - int_request reflects the new mask the following cycle.
  - A mask change never clears pending.
- pend_clr[i]=1 clears pending[i] unless a new edge arrives on the same cycle.

Optional Feature:
- Macro IRQ_NESTING_EN.
- Defined:
  - in_service becomes an internal 8-bit ISR; the output in_service = |ISR.
  - ack sets ISR[sel].
  - int_request is asserted when sel has strictly higher priority (lower index) than the lowest set ISR bit, or ISR is empty.
  - eoi clears the lowest set ISR bit.
- Undefined: single in-service bit as above, so no nesting.

Test Plan:
- Reset, then pulse irq_in[3] high for 3 cycles with irq_masks=8'h00:
  - pending=8'h08 two cycles after first sample.
  - int_request=0.
- Then mask_wr with mask_data=8'h08:
  - int_request=1 next cycle.
  - int_ack -> int_vector=3, pending=8'h00, in_service=1, int_request=0.
- irq_in[5] and irq_in[1] rise in the same cycle, masks=8'hFF:
  - First ack gives int_vector=1.
  - eoi, then second ack gives int_vector=5.
- In the same cycle as an ack of line 2, a new edge on line 2 becomes pending:
  - After the ack, pending[2]=1 and int_vector=2.
  - Also check int_ack with int_request=0 leaves all state unchanged.
- rst_n=0 for one cycle during in_service=1 with pending=8'h30:
  - All outputs return to 0 on that edge.
- With IRQ_NESTING_EN, line 4 in service:
  - An edge on line 6 gives int_request=0.
  - An edge on line 2 gives int_request=1; ack -> int_vector=2.
  - eoi clears ISR bit 2; in_service stays 1.
